// File: rtl/perf_event_counter.sv
// rtl/perf_event_counter.sv - event and cycle performance counters with freeze-on-halt and registered read port
module perf_event_counter #(
  parameter int NUM_EVT  = 6,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_EVT-1:0]             evt,
  input  logic                           halt,
  input  logic                           clr,
  input  logic [$clog2(NUM_EVT+1)-1:0]   rd_sel,
  output logic [CNT_W-1:0]               rd_data,
  output logic [NUM_EVT:0]               ovf,
  output logic                           frozen,
  output logic                           running
);

  localparam int NCNT  = NUM_EVT + 1;
  localparam int SEL_W = $clog2(NUM_EVT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} stateT;

  stateT            state, nextState;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [NCNT-1:0]  ovfReg;
  logic [NCNT-1:0]  incReq;
  logic [CNT_W-1:0] selVal;

  always_comb begin
    nextState = state;
    if (clr) begin
      nextState = en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) nextState = RUN;
        RUN:     if (halt) nextState = FROZEN;
                 else if (!en) nextState = IDLE;
        FROZEN:  nextState = FROZEN;
        default: nextState = IDLE;
      endcase
    end
  end

  // Top bit is the cycle counter, which ticks on every RUN cycle including the halt cycle.
  assign incReq = (state == RUN && !clr) ? {1'b1, evt} : '0;

  always_comb begin
    selVal = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SEL_W'(i)) selVal = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rd_data <= '0;
      ovfReg  <= '0;
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else begin
      state   <= nextState;
      rd_data <= selVal;
      if (clr) begin
        ovfReg <= '0;
        for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < NCNT; i++) begin
          if (incReq[i]) begin
            if (cnt[i] == CNT_MAX) begin
              ovfReg[i] <= 1'b1;
              if (!SATURATE) cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign ovf     = ovfReg;
  assign frozen  = (state == FROZEN);
  assign running = (state == RUN);

endmodule

// File: tb/tb_perf_event_counter.sv
// tb/tb_perf_event_counter.sv - self-checking bench comparing wide, wrap and saturate instances to an unbounded-count model
module tb_perf_event_counter;

  localparam int NUM_EVT = 6;
  localparam int NCNT    = NUM_EVT + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0, halt = 1'b0, clr = 1'b0;
  logic [NUM_EVT-1:0] evt = '0;
  logic [2:0]         rdSel = '0;
  logic [31:0]        rdA;
  logic [3:0]         rdW, rdS;
  logic [NCNT-1:0]    ovfA, ovfW, ovfS;
  logic               frozenA, frozenW, frozenS, runningA, runningW, runningS;

  perf_event_counter #(.NUM_EVT(NUM_EVT), .CNT_W(32), .SATURATE(1'b0)) dutA (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdA), .ovf(ovfA), .frozen(frozenA), .running(runningA));
  perf_event_counter #(.NUM_EVT(NUM_EVT), .CNT_W(4), .SATURATE(1'b0)) dutW (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdW), .ovf(ovfW), .frozen(frozenW), .running(runningW));
  perf_event_counter #(.NUM_EVT(NUM_EVT), .CNT_W(4), .SATURATE(1'b1)) dutS (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdS), .ovf(ovfS), .frozen(frozenS), .running(runningS));

  always #5 clk = ~clk;

  int     nAssert = 0;
  int     nFail = 0;
  bit     chkOn = 1'b0;
  longint trueCnt [NCNT];
  longint snap [NCNT];
  longint expSel = 0;
  int     mode = 0;  // 0 idle, 1 run, 2 frozen

  function automatic longint fold(input longint c, input int w, input bit sat);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (sat) return (c > mx) ? mx : c;
    return c & mx;
  endfunction

  function automatic logic [NCNT-1:0] ovfOf(input int w);
    logic [NCNT-1:0] v;
    v = '0;
    for (int i = 0; i < NCNT; i++) v[i] = (trueCnt[i] >= (longint'(1) << w));
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts are kept unbounded; each instance's view is derived by folding to its width.
  function automatic void modelStep();
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) trueCnt[i] = 0;
      mode   = 0;
      expSel = 0;
    end else begin
      expSel = 0;
      if (rdSel <= 3'(NUM_EVT)) expSel = trueCnt[rdSel];
      if (clr) begin
        for (int i = 0; i < NCNT; i++) trueCnt[i] = 0;
        mode = en ? 1 : 0;
      end else if (mode == 1) begin
        for (int i = 0; i < NUM_EVT; i++) if (evt[i]) trueCnt[i]++;
        trueCnt[NUM_EVT]++;
        if (halt) mode = 2;
        else if (!en) mode = 0;
      end else if (mode == 0 && en) begin
        mode = 1;
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      check("rdA", 64'(rdA), fold(expSel, 32, 1'b0));
      check("rdW", 64'(rdW), fold(expSel, 4, 1'b0));
      check("rdS", 64'(rdS), fold(expSel, 4, 1'b1));
      check("ovfA", 64'(ovfA), 64'(ovfOf(32)));
      check("ovfW", 64'(ovfW), 64'(ovfOf(4)));
      check("ovfS", 64'(ovfS), 64'(ovfOf(4)));
      check("frozenA", 64'(frozenA), 64'(mode == 2));
      check("frozenW", 64'(frozenW), 64'(mode == 2));
      check("frozenS", 64'(frozenS), 64'(mode == 2));
      check("runningA", 64'(runningA), 64'(mode == 1));
      check("runningW", 64'(runningW), 64'(mode == 1));
      check("runningS", 64'(runningS), 64'(mode == 1));
    end
  end

  initial begin
    for (int i = 0; i < NCNT; i++) begin trueCnt[i] = 0; snap[i] = 0; end
    step(2);
    chkOn = 1'b1;
    check("reset rd_data", 64'(rdA), 0);
    check("reset ovf", 64'(ovfA), 0);
    check("reset running", 64'(runningA), 0);
    rst = 1'b1;

    // ten counted RUN cycles for channel 0 and the cycle counter
    en = 1'b1; step(1);
    evt = 6'b000001; step(9);
    en = 1'b0; step(1);
    evt = '0; rdSel = 3'd0; step(1);
    check("evt0 count", 64'(rdA), 10);
    rdSel = 3'd6; step(1);
    check("cycle count", 64'(rdA), 10);
    check("running after en drop", 64'(runningA), 0);

    // halt cycle is counted, later events are not
    clr = 1'b1; en = 1'b1; step(1); clr = 1'b0;
    step(2);
    evt = 6'b001000; halt = 1'b1; step(1); halt = 1'b0;
    check("frozen after halt", 64'(frozenA), 1);
    check("running after halt", 64'(runningA), 0);
    step(5);
    evt = '0; rdSel = 3'd3; step(1);
    check("evt3 count", 64'(rdA), 1);
    rdSel = 3'd6; step(1);
    check("cycle count frozen", 64'(rdA), 3);

    // clear out of FROZEN straight into RUN, then overflow channel 1
    clr = 1'b1; en = 1'b1; evt = '1; step(1); clr = 1'b0; evt = '0;
    check("running after clr", 64'(runningA), 1);
    check("ovf after clr", 64'(ovfA), 0);
    check("frozen after clr", 64'(frozenA), 0);
    rdSel = 3'd6; step(1);
    check("cycle after clr", 64'(rdA), 0);
    evt = 6'b000010; rdSel = 3'd1; step(17);
    evt = '0; en = 1'b0; step(1);
    step(1);
    check("wrap value", 64'(rdW), 1);
    check("wrap ovf", 64'(ovfW[1]), 1);
    check("sat value", 64'(rdS), 15);
    check("sat ovf", 64'(ovfS[1]), 1);
    check("wide value", 64'(rdA), 17);

    rdSel = 3'd7; step(1);
    check("out of range sel", 64'(rdA), 0);
    check("out of range sel wrap", 64'(rdW), 0);

    // reset mid-count
    en = 1'b1; evt = 6'b101010; rdSel = 3'd5; step(4);
    rst = 1'b0; step(1); rst = 1'b1;
    check("mid reset rd_data", 64'(rdA), 0);
    check("mid reset ovfW", 64'(ovfW), 0);
    check("mid reset running", 64'(runningA), 0);
    check("mid reset frozen", 64'(frozenA), 0);
    en = 1'b0; step(2);

    // random stream ending in halt, then nothing may move
    clr = 1'b1; step(1); clr = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      evt   = 6'($urandom);
      rdSel = 3'($urandom_range(0, 7));
      step(1);
    end
    en = 1'b1; evt = 6'($urandom); step(1);
    halt = 1'b1; evt = 6'($urandom); step(1); halt = 1'b0;
    check("frozen after random", 64'(frozenA), 1);
    snap = trueCnt;
    for (int c = 0; c < 20; c++) begin
      en    = 1'($urandom);
      halt  = 1'($urandom);
      evt   = 6'($urandom);
      rdSel = 3'($urandom_range(0, 7));
      step(1);
    end
    for (int i = 0; i < NCNT; i++) begin
      rdSel = 3'(i); step(1);
      check("post-freeze count", 64'(rdA), 64'(snap[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/perf_event_counter.md
# perf_event_counter

Synthesizable, parametrised performance-monitor block for the cached processor hierarchy. Counts up to NUM_EVT single-bit event strobes (retired instructions, I/D-cache requests, I/D-cache hits, …) plus elapsed cycles, then freezes all counts when the processor halts. Sits beside the processor core, sampling its strobes each cycle. Exposes a registered, indexed read port so statistics survive into hardware rather than existing only as simulation-side bookkeeping.

## Interface
Parameters:
- NUM_EVT, 6: number of event channels.
- CNT_W, 32: width of every counter, cycle counter included.
- SATURATE, 0: 0 = counters wrap on overflow; 1 = counters hold at all-ones.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 at a rising edge resets the block).
- en  in  1  counting enable.
- evt  in  NUM_EVT  event strobes; one increment per asserted bit per cycle.
- halt  in  1  processor-halted strobe.
- clr  in  1  synchronous clear of all counters and flags.
- rd_sel  in  $clog2(NUM_EVT+1)  read index; 0..NUM_EVT-1 selects an event counter, NUM_EVT selects the cycle counter.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT is the cycle counter's flag.
- frozen  out  1  high while in FROZEN.
- running  out  1  high while in RUN.

## Operation
- State machine with states IDLE, RUN and FROZEN; reset state is IDLE.
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - RUN -> FROZEN when halt=1.
  - FROZEN -> IDLE only through clr or reset. en and halt are ignored in FROZEN.
- Counting in RUN:
  - The cycle counter increments every cycle.
  - Event counter i increments when evt[i]=1.
  - The halt cycle itself is counted: events and the cycle count for the cycle with halt=1 are included, and counting stops from the next cycle.
- Counting elsewhere: no counter changes in IDLE or FROZEN. halt received in IDLE has no effect.
- Overflow, applied per counter:
  - Wrap mode (SATURATE=0): an increment from all-ones gives 0 and sets the counter's ovf bit.
  - Saturate mode (SATURATE=1): an increment from all-ones leaves the counter at all-ones and sets the counter's ovf bit.
  - ovf bits are sticky until clr or reset.
- clr has priority over everything. For the cycle clr=1:
  - all counters and ovf bits are set to 0;
  - the state becomes RUN if en=1, otherwise IDLE;
  - the events present in that cycle are not counted.
- Read port:
  - rd_data is loaded each cycle with the value selected by rd_sel, as it stood before that edge's update.
  - Any rd_sel value greater than NUM_EVT returns 0.
- Reset values: all counters 0; rd_data=0; ovf=0; frozen=0; running=0. Reset applied mid-run discards all counts.

## Timing
- Event-to-count latency is 1 cycle: a strobe at edge k is visible in the counter after edge k.
- Read latency is 1 cycle: rd_sel presented before edge k gives rd_data valid after edge k. A counter incremented at edge k is therefore readable on rd_data after edge k+1.
- frozen rises the cycle after halt is sampled in RUN. running falls in that same cycle.
- Simultaneous events:
  - halt together with clr: clr wins and the block does not freeze.
  - halt together with en=0 in RUN: FROZEN wins, and that cycle's events are counted.
- No combinational path from any input to any output.

## Test plan
- Reset, then en=1 and evt=6'b000001 for 10 cycles, then en=0. Read rd_sel=0 -> 10; rd_sel=6 (cycle counter) -> 10; running=0 after en drops.
- In RUN, pulse evt[3] and halt in the same cycle, then keep evt[3]=1 for 5 more cycles. Required: evt[3] count is 1, frozen=1 from the next cycle, and the cycle count stops increasing.
- CNT_W=4, SATURATE=0, evt[1]=1 for 17 cycles. Required: counter 1 reads 1 and ovf[1]=1. Repeat with SATURATE=1: counter reads 15 and ovf[1]=1.
- While FROZEN with nonzero counts, assert clr with en=1. Required: all counters 0, ovf=0, running=1 the next cycle, and counts resume from 0.
- rd_sel=7 with NUM_EVT=6 -> rd_data=0. Drive rst=0 for one edge mid-count -> all outputs 0 and state IDLE.
- Random evt/en stream for 1000 cycles ending in halt. Per-channel counts must match a scoreboard, and nothing may change after frozen rises.
